// File: rtl/alu_pkg.sv
// Shared types for the ALU write-back stage: op codes, skid-buffer FSM states
// and the buffered entry layout.
package alu_pkg;

  localparam int unsigned AluW = 64;
  localparam int unsigned TagW = 5;
  localparam int unsigned CntW = 32;

  typedef enum logic [1:0] {
    OpAnd = 2'b00,
    OpOr  = 2'b01,
    OpAdd = 2'b10,
    OpSub = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic [AluW-1:0] result;
    logic [TagW-1:0] tag;
    alu_op_e         op;
    logic            neg;
    logic            zero;
  } wb_entry_t;

endpackage

// File: rtl/wb_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module wb_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_wb_stage.sv
// Registered write-back stage behind the ALU: 2-entry skid buffer with
// valid/ready handshake, flag capture, zero-flag check and retire counter.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = AluW,
  parameter int unsigned TAG_W = TagW,
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       alu_control_i,
  input  logic [N-1:0]     result_i,
  input  logic             zero_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [N-1:0]     result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [1:0]       op_o,
  output logic [1:0]       flags_o,
  output logic             err_o,
  output logic [CNT_W-1:0] op_count_o
);

  wb_state_e state_q, state_d;
  wb_entry_t head_q, head_d;
  wb_entry_t skid_q, skid_d;
  wb_entry_t in_entry;
  logic      ready_q, ready_d;
  logic      err_q, err_d;
  logic      accept, retire;

  assign accept = valid_i && ready_q;
  assign retire = (state_q != StEmpty) && ready_i;

  always_comb begin
    in_entry.result = result_i;
    in_entry.tag    = tag_i;
    in_entry.op     = alu_op_e'(alu_control_i);
    in_entry.neg    = result_i[N-1];
    in_entry.zero   = zero_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          head_d  = in_entry;
        end
      end
      StOne: begin
        if (accept && retire) begin
          head_d = in_entry;
        end else if (accept) begin
          state_d = StTwo;
          skid_d  = in_entry;
        end else if (retire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (retire) begin
          state_d = StOne;
          head_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // ready_o is a flop so the upstream never sees a combinational path from ready_i.
  assign ready_d = (state_d != StTwo);
  assign err_d   = err_q || (accept && (zero_i != (result_i == '0)));

  always_comb begin
    valid_o  = (state_q != StEmpty);
    ready_o  = ready_q;
    result_o = head_q.result;
    tag_o    = head_q.tag;
    op_o     = head_q.op;
    flags_o  = {head_q.neg, head_q.zero};
    err_o    = err_q;
  end

  wb_sat_counter #(
    .Width (CNT_W)
  ) u_retire_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (retire),
    .cnt_o  (op_count_o)
  );

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus random traffic
// against a queue-based reference of the write-back buffer.
module tb_alu_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  alu_control_i;
  logic [63:0] result_i;
  logic        zero_i;
  logic [4:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic [4:0]  tag_o;
  logic [1:0]  op_o;
  logic [1:0]  flags_o;
  logic        err_o;
  logic [31:0] op_count_o;

  always #5 clk_i = ~clk_i;

  alu_wb_stage dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .alu_control_i (alu_control_i),
    .result_i      (result_i),
    .zero_i        (zero_i),
    .tag_i         (tag_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .tag_o         (tag_o),
    .op_o          (op_o),
    .flags_o       (flags_o),
    .err_o         (err_o),
    .op_count_o    (op_count_o)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
    logic [1:0]  op;
    logic        z;
  } ref_t;

  ref_t        mq[$];
  logic        m_err;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_o", 64'(valid_o), 64'(mq.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(mq.size() < 2));
    chk("err_o", 64'(err_o), 64'(m_err));
    chk("op_count_o", 64'(op_count_o), 64'(m_cnt));
    if (mq.size() > 0) begin
      chk("result_o", result_o, mq[0].res);
      chk("tag_o", 64'(tag_o), 64'(mq[0].tag));
      chk("op_o", 64'(op_o), 64'(mq[0].op));
      chk("flags_o", 64'(flags_o), 64'({mq[0].res[63], mq[0].z}));
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_i);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_result_o", result_o, 64'd0);
    chk("rst_tag_o", 64'(tag_o), 64'd0);
    chk("rst_op_o", 64'(op_o), 64'd0);
    chk("rst_flags_o", 64'(flags_o), 64'd0);
    chk("rst_err_o", 64'(err_o), 64'd0);
    chk("rst_count", 64'(op_count_o), 64'd0);
    rst_ni = 1'b1;
  endtask

  // One clock: drive inputs, advance the reference at the edge, check on the falling edge.
  task automatic step(input logic v, input logic [63:0] res, input logic z,
                      input logic [4:0] t, input logic [1:0] op, input logic rdy);
    logic acc, ret;
    ref_t e;
    valid_i = v; result_i = res; zero_i = z; tag_i = t; alu_control_i = op; ready_i = rdy;
    @(posedge clk_i);
    acc = v && (mq.size() < 2);
    ret = (mq.size() > 0) && rdy;
    if (ret) begin
      mq.delete(0);
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (acc) begin
      e.res = res; e.tag = t; e.op = op; e.z = z;
      mq.push_back(e);
      if (z != (res == 64'd0)) m_err = 1'b1;
    end
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    logic [31:0] cnt0;
    logic [63:0] r;
    valid_i = 1'b0; result_i = '0; zero_i = 1'b0; tag_i = '0; alu_control_i = '0;
    ready_i = 1'b0; rst_ni = 1'b0;

    do_reset();

    // Single op: visible one cycle after accept, retired the cycle after.
    step(1'b1, 64'd5, 1'b0, 5'd3, 2'b10, 1'b1);
    chk("single_result", result_o, 64'd5);
    chk("single_tag", 64'(tag_o), 64'd3);
    chk("single_flags", 64'(flags_o), 64'd0);
    step(1'b0, 64'd0, 1'b0, 5'd0, 2'b00, 1'b1);
    chk("single_count", 64'(op_count_o), 64'd1);

    // Back-pressure: third push is refused while full, then everything drains in order.
    step(1'b1, 64'h11, 1'b0, 5'd1, 2'b00, 1'b0);
    step(1'b1, 64'h22, 1'b0, 5'd2, 2'b01, 1'b0);
    chk("bp_full_ready", 64'(ready_o), 64'd0);
    step(1'b1, 64'h33, 1'b0, 5'd3, 2'b10, 1'b0);
    chk("bp_head_tag", 64'(tag_o), 64'd1);
    step(1'b1, 64'h33, 1'b0, 5'd3, 2'b10, 1'b1);
    chk("bp_second_tag", 64'(tag_o), 64'd2);
    step(1'b1, 64'h33, 1'b0, 5'd3, 2'b10, 1'b1);
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);
    chk("bp_third_tag", 64'(tag_o), 64'd3);
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);

    // Streaming SUB ops at full rate.
    cnt0 = m_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'(100 + i), 1'b0, 5'(i + 8), 2'b11, 1'b1);
      chk("stream_ready", 64'(ready_o), 64'd1);
    end
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);
    chk("stream_count", 64'(op_count_o), 64'(cnt0 + 8));

    // Flags.
    step(1'b1, 64'h8000_0000_0000_0000, 1'b0, 5'd4, 2'b10, 1'b1);
    chk("flags_neg", 64'(flags_o), 64'b10);
    step(1'b1, 64'h0, 1'b1, 5'd5, 2'b11, 1'b1);
    chk("flags_zero", 64'(flags_o), 64'b01);
    chk("flags_err", 64'(err_o), 64'd0);

    // Zero-flag mismatch is sticky until reset.
    step(1'b1, 64'h0, 1'b0, 5'd6, 2'b00, 1'b1);
    chk("mismatch_err", 64'(err_o), 64'd1);
    step(1'b1, 64'h7, 1'b0, 5'd7, 2'b01, 1'b1);
    step(1'b1, 64'h0, 1'b1, 5'd8, 2'b10, 1'b1);
    chk("mismatch_sticky", 64'(err_o), 64'd1);
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);
    do_reset();

    // Random traffic with consistent zero flags.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), r, 1'(r == 64'd0), 5'($urandom),
           2'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset while full.
    step(1'b1, 64'h55, 1'b0, 5'd9, 2'b10, 1'b0);
    step(1'b1, 64'h66, 1'b0, 5'd10, 2'b10, 1'b0);
    step(1'b1, 64'h77, 1'b0, 5'd11, 2'b10, 1'b0);
    chk("pre_async_valid", 64'(valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_valid_o", 64'(valid_o), 64'd0);
    chk("async_ready_o", 64'(ready_o), 64'd1);
    chk("async_count", 64'(op_count_o), 64'd0);
    chk("async_err", 64'(err_o), 64'd0);
    model_clear();
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);
    step(1'b1, 64'h9, 1'b0, 5'd12, 2'b00, 1'b1);
    step(1'b0, 64'h0, 1'b0, 5'd0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
